// File: rtl/nasti_lite_host_master.sv
// ---------------------------------------------------------------------------
// nasti_lite_host_master
//
// Single-outstanding NASTI-Lite initiator. A host-side agent (boot loader,
// debug bridge) issues one read or write on a simple command port; the block
// runs the matching AW/W/B or AR/R exchange on the IO bus and returns the
// outcome on a buffered response port. Only one transaction is ever in flight.
//
// Ports
//   clk, rstn            single clock; asynchronous active-low reset
//   cmd_*                command in  (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                response out (valid/ready, write, rdata, resp)
//   nasti_aw_*           write address channel (initiator side)
//   nasti_w_*            write data channel
//   nasti_b_*            write response channel
//   nasti_ar_*           read address channel
//   nasti_r_*            read data channel
//
// Every valid/ready output is a pure decode of registered state, so there is
// no combinational path from any incoming ready to any outgoing valid.
// ---------------------------------------------------------------------------
module nasti_lite_host_master #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned MASTER_ID  = 0
) (
    input  logic                      clk,
    input  logic                      rstn,

    // command port
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

    // write address channel
    output logic                      nasti_aw_valid,
    input  logic                      nasti_aw_ready,
    output logic [ID_WIDTH-1:0]       nasti_aw_id,
    output logic [ADDR_WIDTH-1:0]     nasti_aw_addr,
    output logic [2:0]                nasti_aw_prot,
    output logic [3:0]                nasti_aw_qos,
    output logic [3:0]                nasti_aw_region,
    output logic [0:0]                nasti_aw_user,

    // write data channel
    output logic                      nasti_w_valid,
    input  logic                      nasti_w_ready,
    output logic [DATA_WIDTH-1:0]     nasti_w_data,
    output logic [DATA_WIDTH/8-1:0]   nasti_w_strb,
    output logic [0:0]                nasti_w_user,

    // write response channel
    input  logic                      nasti_b_valid,
    output logic                      nasti_b_ready,
    input  logic [ID_WIDTH-1:0]       nasti_b_id,
    input  logic [1:0]                nasti_b_resp,

    // read address channel
    output logic                      nasti_ar_valid,
    input  logic                      nasti_ar_ready,
    output logic [ID_WIDTH-1:0]       nasti_ar_id,
    output logic [ADDR_WIDTH-1:0]     nasti_ar_addr,
    output logic [2:0]                nasti_ar_prot,
    output logic [3:0]                nasti_ar_qos,
    output logic [3:0]                nasti_ar_region,
    output logic [0:0]                nasti_ar_user,

    // read data channel
    input  logic                      nasti_r_valid,
    output logic                      nasti_r_ready,
    input  logic [ID_WIDTH-1:0]       nasti_r_id,
    input  logic [DATA_WIDTH-1:0]     nasti_r_data,
    input  logic [1:0]                nasti_r_resp
);

    localparam int unsigned          STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ID_WIDTH-1:0]  OWN_ID     = ID_WIDTH'(MASTER_ID);
    localparam logic [1:0]           RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    // registered command
    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;

    // per-channel completion flags for the write address/data phase
    logic                    aw_done_q;
    logic                    w_done_q;

    // buffered response
    logic                    rsp_write_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]              rsp_resp_q;

    // Holds cmd_ready low while rstn is asserted: state sits at IDLE during
    // reset, but no ready may be advertised until reset has been released.
    logic                    out_of_reset_q;

    logic                    cmd_hs;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;

    // ------------------------------------------------------------------
    // Handshake/valid decode (registered state only)
    // ------------------------------------------------------------------
    assign cmd_ready      = (state_q == IDLE) && out_of_reset_q;
    assign nasti_aw_valid = (state_q == WADDR) && !aw_done_q;
    assign nasti_w_valid  = (state_q == WADDR) && !w_done_q;
    assign nasti_b_ready  = (state_q == WRESP);
    assign nasti_ar_valid = (state_q == RADDR);
    assign nasti_r_ready  = (state_q == RDATA);
    assign rsp_valid      = (state_q == RSP);

    assign cmd_hs = cmd_valid      && cmd_ready;
    assign aw_hs  = nasti_aw_valid && nasti_aw_ready;
    assign w_hs   = nasti_w_valid  && nasti_w_ready;
    assign b_hs   = nasti_b_valid  && nasti_b_ready;
    assign ar_hs  = nasti_ar_valid && nasti_ar_ready;
    assign r_hs   = nasti_r_valid  && nasti_r_ready;

    // ------------------------------------------------------------------
    // Channel payloads: taken from the command registers, so they stay
    // stable for as long as the matching valid is high.
    // ------------------------------------------------------------------
    assign nasti_aw_id     = OWN_ID;
    assign nasti_aw_addr   = addr_q;
    assign nasti_aw_prot   = '0;
    assign nasti_aw_qos    = '0;
    assign nasti_aw_region = '0;
    assign nasti_aw_user   = '0;

    assign nasti_w_data    = wdata_q;
    assign nasti_w_strb    = wstrb_q;
    assign nasti_w_user    = '0;

    assign nasti_ar_id     = OWN_ID;
    assign nasti_ar_addr   = addr_q;
    assign nasti_ar_prot   = '0;
    assign nasti_ar_qos    = '0;
    assign nasti_ar_region = '0;
    assign nasti_ar_user   = '0;

    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so that no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    state_d = cmd_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                // AW and W complete independently; leave once both have,
                // counting a handshake happening in this very cycle.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    state_d = RSP;
                end
            end
            RADDR: begin
                if (ar_hs) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture, write-phase flags and response buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_of_reset_q <= 1'b0;
            write_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            rsp_write_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_resp_q     <= '0;
        end else begin
            out_of_reset_q <= 1'b1;

            if (cmd_hs) begin
                write_q   <= cmd_write;
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end

            // A flag drops its valid the cycle after its own handshake.
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end

            // A response carrying someone else's ID is reported as SLVERR.
            if (b_hs) begin
                rsp_write_q <= write_q;
                rsp_rdata_q <= '0;
                rsp_resp_q  <= (nasti_b_id == OWN_ID) ? nasti_b_resp : RESP_SLVERR;
            end

            if (r_hs) begin
                rsp_write_q <= write_q;
                rsp_rdata_q <= nasti_r_data;
                rsp_resp_q  <= (nasti_r_id == OWN_ID) ? nasti_r_resp : RESP_SLVERR;
            end
        end
    end

endmodule
